// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {CLEAR, RUN} rf_state_e;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  // Address width with a floor of one bit so tiny depths still get a real bus.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range/zero masking, CLEAR gating and write bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned AW       = clog2_min1(NUM_REGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     run,
  input  logic [DATA_W-1:0]        regs [NUM_REGS],
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_REGS);

  logic in_range;
  logic is_zero;

  assign in_range = ({1'b0, rd_addr} < DEPTH);
  assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);

  // Ascending port scan so the highest-index matching writer wins the bypass.
  always_comb begin
    rd_data = '0;
    if (run && in_range && !is_zero) begin
      rd_data = regs[rd_addr];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr))
            rd_data = wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised multi-port register file with a post-reset clear sequencer;
// storage carries no reset so it stays RAM-inferable.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = clog2_min1(NUM_REGS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_WR-1:0]        write_enable,
  input  logic [NUM_WR*AW-1:0]     write_address,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  input  logic [NUM_RD*AW-1:0]     read_address,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     ready
);

  localparam logic [AW:0]   DEPTH = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST  = AW'(NUM_REGS-1);

  rf_state_e         state;
  logic [AW-1:0]     clr_cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_WR-1:0] wr_ok;
  logic              run;

  assign run = (state == RUN);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST) begin
        state <= RUN;
        ready <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ok = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_ok[p] = run && write_enable[p]
                 && ({1'b0, write_address[p*AW +: AW]} < DEPTH)
                 && !((ZERO_REG != 0) && (write_address[p*AW +: AW] == '0));
    end
  end

  // Later non-blocking writes override earlier ones, so the highest port wins a collision.
  always_ff @(posedge clk_in) begin
    if (state == CLEAR) begin
      regs[clr_cnt] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p])
          regs[write_address[p*AW +: AW]] <= write_data[p*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .run     (run),
      .regs    (regs),
      .wr_en   (wr_ok),
      .wr_addr (write_address),
      .wr_data (write_data),
      .rd_addr (read_address[g*AW +: AW]),
      .rd_data (read_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench: a dual-write bypassing instance and a 24-deep non-bypassing one.
module tb_param_regfile;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [1:0]  a_we;
  logic [9:0]  a_wa;
  logic [63:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic        a_ready;

  logic [0:0]  b_we;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic [4:0]  b_ra;
  logic [31:0] b_rd;
  logic        b_ready;

  int n_checks = 0;
  int n_fail   = 0;

  param_regfile #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .clk_in(clk_in), .rst_in(rst_in), .write_enable(a_we), .write_address(a_wa),
    .write_data(a_wd), .read_address(a_ra), .read_data(a_rd), .ready(a_ready)
  );

  param_regfile #(
    .DATA_W(32), .NUM_REGS(24), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk_in(clk_in), .rst_in(rst_in), .write_enable(b_we), .write_address(b_wa),
    .write_data(b_wd), .read_address(b_ra), .read_data(b_rd), .ready(b_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Counts edges until each instance raises ready; pending writes drop once ready.
  task automatic wait_ready(input int exp_a, input int exp_b, input string tag);
    int ea = 0;
    int eb = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_in);
      #1;
      if (ea == 0 && a_ready) begin ea = e; a_we = '0; end
      if (eb == 0 && b_ready) begin eb = e; b_we = '0; end
      if (ea == 0) check({tag, "_clr_rd_a"}, a_rd, 64'h0);
      if (eb == 0) check({tag, "_clr_rd_b"}, {32'h0, b_rd}, 64'h0);
      if (ea != 0 && eb != 0) break;
    end
    check({tag, "_ready_edge_a"}, 64'(ea), 64'(exp_a));
    check({tag, "_ready_edge_b"}, 64'(eb), 64'(exp_b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_b;
    a_we = '0; a_wa = '0; a_wd = '0; a_ra = '0;
    b_we = '0; b_wa = '0; b_wd = '0; b_ra = '0;

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready_a", 64'(a_ready), 64'h0);
    check("rst_ready_b", 64'(b_ready), 64'h0);
    check("rst_rd_a", a_rd, 64'h0);

    // Writes held through the whole clear must never land.
    a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'h0, 32'hBAD0BAD0}; a_ra = {5'd0, 5'd9};
    b_we = 1'b1;  b_wa = 5'd2; b_wd = 32'hBAD1BAD1; b_ra = 5'd2;
    rst_in = 1'b0;
    wait_ready(32, 24, "clr1");

    for (int i = 0; i < 32; i++) begin
      a_ra = {5'(31 - i), 5'(i)};
      #1;
      check("clr_all_a", a_rd, 64'h0);
    end
    for (int i = 0; i < 24; i++) begin
      b_ra = 5'(i);
      #1;
      check("clr_all_b", {32'h0, b_rd}, 64'h0);
    end
    tick();

    // Same-cycle write and read of reg5
    a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hDEADBEEF}; a_ra = {5'd0, 5'd5};
    b_we = 1'b1;  b_wa = 5'd5; b_wd = 32'hDEADBEEF; b_ra = 5'd5;
    #1;
    check("byp_same_a", {32'h0, a_rd[31:0]}, 64'hDEADBEEF);
    check("nobyp_same_b", {32'h0, b_rd}, 64'h0);
    tick();
    a_we = '0; b_we = '0;
    #1;
    check("byp_next_a", {32'h0, a_rd[31:0]}, 64'hDEADBEEF);
    check("nobyp_next_b", {32'h0, b_rd}, 64'hDEADBEEF);

    // Address 0
    a_we = 2'b11; a_wa = {5'd0, 5'd0}; a_wd = {32'h12345678, 32'h12345678}; a_ra = '0;
    b_we = 1'b1;  b_wa = 5'd0; b_wd = 32'h12345678; b_ra = 5'd0;
    #1;
    check("zero_same_a", a_rd, 64'h0);
    tick();
    a_we = '0; b_we = '0;
    #1;
    check("zero_next_a", a_rd, 64'h0);
    check("zero_off_b", {32'h0, b_rd}, 64'h12345678);

    // Collision on reg7: port 1 wins
    a_we = 2'b11; a_wa = {5'd7, 5'd7}; a_wd = {32'h0000BBBB, 32'hAAAA0000}; a_ra = {5'd0, 5'd7};
    #1;
    check("coll_byp_a", {32'h0, a_rd[31:0]}, 64'h0000BBBB);
    tick();
    a_we = '0;
    #1;
    check("coll_store_a", {32'h0, a_rd[31:0]}, 64'h0000BBBB);

    // Two writes to distinct registers both commit
    a_we = 2'b11; a_wa = {5'd11, 5'd10}; a_wd = {32'h22222222, 32'h11111111}; a_ra = {5'd11, 5'd10};
    #1;
    check("dual_byp_a", a_rd, 64'h22222222_11111111);
    tick();
    a_we = '0;
    #1;
    check("dual_store_a", a_rd, 64'h22222222_11111111);

    // Out-of-range address on the 24-deep instance
    b_we = 1'b1; b_wa = 5'd30; b_wd = 32'h0000FFFF; b_ra = 5'd30;
    #1;
    check("oor_same_b", {32'h0, b_rd}, 64'h0);
    tick();
    b_we = '0;
    #1;
    check("oor_rd_b", {32'h0, b_rd}, 64'h0);
    for (int i = 0; i < 24; i++) begin
      b_ra = 5'(i);
      #1;
      exp_b = (i == 0) ? 32'h12345678 : (i == 5) ? 32'hDEADBEEF : 32'h0;
      check("oor_keep_b", {32'h0, b_rd}, {32'h0, exp_b});
    end
    tick();

    // Reset in the middle of RUN
    a_we = 2'b01; a_wa = {5'd0, 5'd3}; a_wd = {32'h0, 32'h55};
    b_we = 1'b1;  b_wa = 5'd3; b_wd = 32'h55;
    tick();
    a_we = '0; b_we = '0;
    a_ra = {5'd5, 5'd3}; b_ra = 5'd3;
    #1;
    check("pre_rst_a", {32'h0, a_rd[31:0]}, 64'h55);
    check("pre_rst_b", {32'h0, b_rd}, 64'h55);
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    check("async_ready_a", 64'(a_ready), 64'h0);
    check("async_ready_b", 64'(b_ready), 64'h0);
    check("async_rd_a", a_rd, 64'h0);
    a_we = 2'b01; a_wa = {5'd0, 5'd3}; a_wd = {32'h0, 32'h77};
    b_we = 1'b1;  b_wa = 5'd3; b_wd = 32'h77;
    #1;
    rst_in = 1'b0;
    wait_ready(32, 24, "clr2");
    #1;
    check("post_rst_a", a_rd, 64'h0);
    check("post_rst_b", {32'h0, b_rd}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the core's 32x32 two-read/one-write register file.
- Configurable width, depth, read-port and write-port counts; optional hardwired-zero register 0; optional write-to-read bypass.
- Adds a post-reset clear sequencer, so storage needs no per-bit reset and stays RAM-inferable.
- Sits in the decode stage between instruction decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: register count, 2..64; need not be a power of 2.
- NUM_RD, 2: read ports, 1..4.
- NUM_WR, 1: write ports, 1..2.
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads.
- AW, $clog2(NUM_REGS): address width (derived; do not override).

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  reset; asynchronous, active-high.
- write_enable  in  NUM_WR  per-port write strobe.
- write_address  in  NUM_WR*AW  packed write addresses; port i at [i*AW +: AW].
- write_data  in  NUM_WR*DATA_W  packed write data.
- read_address  in  NUM_RD*AW  packed read addresses.
- read_data  out  NUM_RD*DATA_W  packed read data; combinational.
- ready  out  1  high when the clear sequence is complete and writes are accepted.

Behaviour:
- FSM states: CLEAR, RUN.
- Reset: rst_in high asynchronously forces state=CLEAR, clear counter=0, ready=0. Storage is not reset; while in CLEAR all read_data outputs are forced to 0.
- CLEAR:
  - Each cycle after rst_in deasserts, write 0 to reg[counter] and increment the counter.
  - After the cycle that clears reg[NUM_REGS-1], go to RUN.
  - ready rises NUM_REGS clock edges after reset release.
  - All write_enable inputs are ignored in CLEAR.
- RUN:
  - Writes take effect on the rising edge and are visible to plain reads in the next cycle.
  - Reads are combinational: zero-cycle latency from read_address.
- Write collision: if several ports write the same address in one cycle, the highest port index wins. Writes to different addresses all commit.
- Bypass (BYPASS=1, RUN only): if read_address matches an enabled write_address, read_data = that write_data in the same cycle; highest port index wins.
- BYPASS=0: read returns the stored (old) value until after the edge.
- ZERO_REG=1: address 0 reads 0 on every port, including through bypass. Writes to address 0 are dropped.
- Out-of-range address (>= NUM_REGS, non-power-of-2 depth): the write is dropped and the read returns 0.
- Reset mid-RUN or mid-CLEAR: ready drops immediately and the full clear sequence restarts from 0. Any write that is pending in the reset cycle is lost.
- read_data must be X-free whenever the address inputs are known.

Decomposition:
- Shared package regfile_pkg holds:
  - typedef rf_state_e {CLEAR, RUN};
  - localparam defaults (DATA_W=32, NUM_REGS=32);
  - function clog2_min1 for AW with a minimum of 1.
- One sub-module: regfile_read_port. Per read port it does the address decode, bypass-match priority mux, zero/range masking and CLEAR gating. It is instantiated NUM_RD times via generate.
- Storage, write arbitration and the FSM stay in the top module.

Test Plan:
- Clear timing: defaults; pulse rst_in for 2 cycles -> ready=0 for exactly 32 edges after release, then 1; every register then reads 0x00000000.
- Write/read latency: write reg5=0xDEADBEEF while reading 5 on port 0:
  - BYPASS=1 -> 0xDEADBEEF in the same cycle.
  - BYPASS=0 -> old 0 in that cycle, 0xDEADBEEF in the next.
- Zero register: write 0x12345678 to address 0 -> reads 0 on all ports in the same and later cycles (bypass on). With ZERO_REG=0 -> reads back 0x12345678.
- Dual-port collision (NUM_WR=2): port0 writes reg7=0xAAAA0000 and port1 writes reg7=0x0000BBBB in one cycle -> reg7=0x0000BBBB. Bypass read in that cycle also shows 0x0000BBBB.
- Reset mid-operation: fill reg3=0x55; assert rst_in asynchronously mid-cycle:
  - ready falls without waiting for a clock edge;
  - writes during the following CLEAR are ignored;
  - after 32 edges reg3 reads 0.
- Out-of-range (NUM_REGS=24, AW=5): write address 30 = 0xFFFF -> no stored register changes; read address 30 returns 0.
